// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipeline.
// Takes the registered D/E buffer outputs, runs the ALU, maintains the
// condition-code register and resolves conditional branches. All results
// go through the E/M pipeline register.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   stall                  hold E/M register and CCR
//   flush                  zero the control word and branch flag (bubble)
//   controlSignals_in      control word from D/E buffer
//   readData1_in           operand A, also the branch target
//   readData2_in           operand B, also the store data
//   imm_in                 immediate, replaces B when ALUsrc=1
//   writeAdd_in            destination register
//   function_in            ALU op or branch condition
//   controlSignals_out     registered control word
//   aluResult_out          registered ALU result
//   storeData_out          registered readData2_in
//   writeAdd_out           registered destination
//   ccr_out                {C,N,Z}
//   branchTaken_out        registered branch-taken flag
//   branchTarget_out       registered branch target
module execute_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [CTRL_W-1:0] controlSignals_in,
  input  logic [DATA_W-1:0] readData1_in,
  input  logic [DATA_W-1:0] readData2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [ADDR_W-1:0] writeAdd_in,
  input  logic [2:0]        function_in,
  output logic [CTRL_W-1:0] controlSignals_out,
  output logic [DATA_W-1:0] aluResult_out,
  output logic [DATA_W-1:0] storeData_out,
  output logic [ADDR_W-1:0] writeAdd_out,
  output logic [2:0]        ccr_out,
  output logic              branchTaken_out,
  output logic [DATA_W-1:0] branchTarget_out
);

  localparam int unsigned BitAluSrc = 9;
  localparam int unsigned BitBranch = 8;
  localparam int unsigned BitAluEn  = 0;

  localparam logic [DATA_W:0] One = {{DATA_W{1'b0}}, 1'b1};

  // CCR bit positions within ccr_q: {C,N,Z}
  localparam int unsigned CcrZ = 0;
  localparam int unsigned CcrN = 1;
  localparam int unsigned CcrC = 2;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] result_q, store_q, target_q;
  logic [ADDR_W-1:0] wadd_q;
  logic [2:0]        ccr_q, ccr_d;
  logic              taken_q, taken_d;

  logic              alu_en, is_branch;
  logic [DATA_W:0]   op_a, op_b, alu_wide;
  logic [DATA_W-1:0] alu_result;
  logic              cond;

  assign alu_en    = controlSignals_in[BitAluEn];
  assign is_branch = controlSignals_in[BitBranch];

  // 17-bit datapath; bit DATA_W is carry (add/inc) or borrow (sub/dec).
  always_comb begin
    op_a = {1'b0, readData1_in};
    op_b = {1'b0, controlSignals_in[BitAluSrc] ? imm_in : readData2_in};
    unique case (function_in)
      3'b000:  alu_wide = op_a;
      3'b001:  alu_wide = {1'b0, ~readData1_in};
      3'b010:  alu_wide = op_a + One;
      3'b011:  alu_wide = op_a - One;
      3'b100:  alu_wide = op_a + op_b;
      3'b101:  alu_wide = op_a - op_b;
      3'b110:  alu_wide = op_a & op_b;
      default: alu_wide = op_a | op_b;
    endcase
    alu_result = alu_en ? alu_wide[DATA_W-1:0] : readData1_in;
  end

  // Branch resolution and CCR next state. Branches never update flags from
  // the ALU; a taken conditional branch clears the flag it tested.
  always_comb begin
    ccr_d = ccr_q;
    cond  = 1'b0;
    unique case (function_in)
      3'b000:  cond = ccr_q[CcrZ];
      3'b001:  cond = ccr_q[CcrN];
      3'b010:  cond = ccr_q[CcrC];
      3'b011:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    taken_d = is_branch & cond;

    if (is_branch) begin
      if (taken_d) begin
        unique case (function_in)
          3'b000:  ccr_d[CcrZ] = 1'b0;
          3'b001:  ccr_d[CcrN] = 1'b0;
          3'b010:  ccr_d[CcrC] = 1'b0;
          default: ccr_d = ccr_q;
        endcase
      end
    end else if (alu_en && (function_in != 3'b000)) begin
      ccr_d[CcrZ] = (alu_wide[DATA_W-1:0] == '0);
      ccr_d[CcrN] = alu_wide[DATA_W-1];
      // NOT/AND/OR leave carry alone
      if (function_in inside {3'b010, 3'b011, 3'b100, 3'b101}) begin
        ccr_d[CcrC] = alu_wide[DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      result_q <= '0;
      store_q  <= '0;
      wadd_q   <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      ccr_q    <= '0;
    end else if (!stall) begin
      result_q <= alu_result;
      store_q  <= readData2_in;
      wadd_q   <= writeAdd_in;
      target_q <= readData1_in;
      if (flush) begin
        ctrl_q  <= '0;
        taken_q <= 1'b0;
      end else begin
        ctrl_q  <= controlSignals_in;
        taken_q <= taken_d;
        ccr_q   <= ccr_d;
      end
    end
  end

  assign controlSignals_out = ctrl_q;
  assign aluResult_out      = result_q;
  assign storeData_out      = store_q;
  assign writeAdd_out       = wadd_q;
  assign ccr_out            = ccr_q;
  assign branchTaken_out    = taken_q;
  assign branchTarget_out   = target_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [10:0] ctrl_in;
  logic [15:0] rd1, rd2, imm;
  logic [2:0]  wa, func;
  logic [10:0] ctrl_out;
  logic [15:0] res_out, store_out, target_out;
  logic [2:0]  wa_out, ccr_out;
  logic        taken_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_ctrl, m_res, m_store, m_wa, m_target;
  bit          m_taken, m_c, m_n, m_z;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .controlSignals_in  (ctrl_in),
    .readData1_in       (rd1),
    .readData2_in       (rd2),
    .imm_in             (imm),
    .writeAdd_in        (wa),
    .function_in        (func),
    .controlSignals_out (ctrl_out),
    .aluResult_out      (res_out),
    .storeData_out      (store_out),
    .writeAdd_out       (wa_out),
    .ccr_out            (ccr_out),
    .branchTaken_out    (taken_out),
    .branchTarget_out   (target_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, computed from the instruction rules.
  task automatic model_edge();
    int unsigned a, b, r, f;
    bit alu_en, br, cond, upd_zn, upd_c, cval;
    if (rst) begin
      {m_ctrl, m_res, m_store, m_wa, m_target} = '0;
      {m_taken, m_c, m_n, m_z} = '0;
      return;
    end
    if (stall) return;
    a = rd1;
    b = ctrl_in[9] ? imm : rd2;
    f = func;
    alu_en = ctrl_in[0];
    br = ctrl_in[8];
    upd_zn = 0; upd_c = 0; cval = 0;
    case (f)
      0: r = a;
      1: begin r = (~a) & 32'hFFFF; upd_zn = 1; end
      2: begin r = (a + 1) & 32'hFFFF; upd_zn = 1; upd_c = 1; cval = (a == 32'hFFFF); end
      3: begin r = (a + 32'hFFFF) & 32'hFFFF; upd_zn = 1; upd_c = 1; cval = (a == 0); end
      4: begin r = (a + b) & 32'hFFFF; upd_zn = 1; upd_c = 1; cval = (a + b) > 32'hFFFF; end
      5: begin r = (a - b) & 32'hFFFF; upd_zn = 1; upd_c = 1; cval = (a < b); end
      6: begin r = a & b; upd_zn = 1; end
      default: begin r = a | b; upd_zn = 1; end
    endcase
    m_res    = alu_en ? r : a;
    m_store  = rd2;
    m_wa     = wa;
    m_target = rd1;
    if (flush) begin
      m_ctrl  = 0;
      m_taken = 0;
      return;
    end
    m_ctrl = ctrl_in;
    if (br) begin
      cond = (f == 0) ? m_z : (f == 1) ? m_n : (f == 2) ? m_c : (f == 3);
      m_taken = cond;
      if (cond && f == 0) m_z = 0;
      if (cond && f == 1) m_n = 0;
      if (cond && f == 2) m_c = 0;
    end else begin
      m_taken = 0;
      if (alu_en && upd_zn) begin
        m_z = (r == 0);
        m_n = r[15];
        if (upd_c) m_c = cval;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("ctrl",   32'(ctrl_out),   m_ctrl);
    check_eq("result", 32'(res_out),    m_res);
    check_eq("store",  32'(store_out),  m_store);
    check_eq("waddr",  32'(wa_out),     m_wa);
    check_eq("ccr",    32'(ccr_out),    {29'd0, m_c, m_n, m_z});
    check_eq("taken",  32'(taken_out),  32'(m_taken));
    check_eq("target", 32'(target_out), m_target);
  endtask

  task automatic drive(input logic [10:0] c, input logic [2:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] i, input logic [2:0] w);
    ctrl_in = c; func = f; rd1 = a; rd2 = b; imm = i; wa = w;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [66:0] snap;

  initial begin
    rst = 1; stall = 0; flush = 0;
    drive(11'h000, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    tick(); tick();
    check_eq("rst_ccr", 32'(ccr_out), 32'd0);
    rst = 0;
    tick();
    check_eq("nop_ctrl", 32'(ctrl_out), 32'd0);

    drive(11'h401, 3'd4, 16'hFFFF, 16'h0001, 16'h0, 3'd2);   // ADD
    tick();
    check_eq("add_res", 32'(res_out), 32'h0000);
    check_eq("add_ccr", 32'(ccr_out), 32'b101);
    drive(11'h401, 3'd5, 16'h0003, 16'h0005, 16'h0, 3'd3);   // SUB
    tick();
    check_eq("sub_res", 32'(res_out), 32'hFFFE);
    check_eq("sub_ccr", 32'(ccr_out), 32'b110);
    drive(11'h601, 3'd7, 16'h0005, 16'h1234, 16'h0010, 3'd1); // OR imm
    tick();
    check_eq("or_res", 32'(res_out), 32'h0015);
    check_eq("or_ccr", 32'(ccr_out), 32'b100);
    drive(11'h601, 3'd6, 16'h0005, 16'h1234, 16'h0010, 3'd1); // AND imm
    tick();
    check_eq("and_ccr", 32'(ccr_out), 32'b101);

    drive(11'h100, 3'd0, 16'h0040, 16'h0, 16'h0, 3'd0);      // JZ taken
    tick();
    check_eq("jz_taken",  32'(taken_out), 32'd1);
    check_eq("jz_target", 32'(target_out), 32'h0040);
    check_eq("jz_ccr",    32'(ccr_out), 32'b100);
    tick();                                                  // JZ again
    check_eq("jz2_taken", 32'(taken_out), 32'd0);

    snap = {ctrl_out, res_out, store_out, wa_out, ccr_out, taken_out, target_out};
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(11'h401, 3'(i + 4), 16'($urandom), 16'($urandom), 16'h0, 3'(i));
      tick();
    end
    flush = 1;
    tick();
    check_eq("stall_hold", 32'({ctrl_out, res_out, store_out, wa_out, ccr_out, taken_out,
                                target_out} == snap), 32'd1);
    stall = 0;
    drive(11'h401, 3'd4, 16'hFFFF, 16'h0001, 16'h0, 3'd5);   // flushed ADD
    tick();
    check_eq("flush_ctrl", 32'(ctrl_out), 32'd0);
    check_eq("flush_ccr",  32'(ccr_out), 32'b100);
    flush = 0;
    drive(11'h100, 3'd3, 16'h0080, 16'h0, 16'h0, 3'd0);      // JMP under reset
    rst = 1;
    tick();
    check_eq("rst_jmp_taken", 32'(taken_out), 32'd0);
    check_eq("rst_jmp_ccr",   32'(ccr_out), 32'd0);
    rst = 0;

    for (int n = 0; n < 3000; n++) begin
      logic [10:0] c;
      c = 11'($urandom);
      if (c[8]) c[0] = 1'b0;
      else if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive(c, 3'($urandom), pick16(), pick16(), pick16(), 3'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
